// File: rtl/wb_burst_ram.sv
// wb_burst_ram: Wishbone B4 slave RAM with CTI/BTE bursts, byte-lane writes and bus error
module wb_burst_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH/8,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic                    ack_o,
  output logic                    err_o
);
  localparam int AL = $clog2(SELECT_WIDTH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] cnt, nxt, mask, wa;
  logic [ADDR_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] wdat;
  logic [15:0] wmask;
  logic in_range, hs, wr;
  // address decode, wrap arithmetic and lane-merged write data
  always_comb begin
    word = adr_i >> AL;
    in_range = (word >> MEM_ADDR_WIDTH) == '0;
    hs = cyc_i & stb_i & ack_o;
    wr = hs & we_i;
    wa = state == BURST ? cnt : word[MEM_ADDR_WIDTH-1:0];
    wmask = bte_i == 2'b01 ? 16'h3 : bte_i == 2'b10 ? 16'h7 : 16'hf;
    mask = bte_i == 2'b00 ? '1 : MEM_ADDR_WIDTH'(wmask);
    nxt = (cnt & ~mask) | ((cnt + MEM_ADDR_WIDTH'(1)) & mask);
    wdat = mem[wa];
    for (int i = 0; i < SELECT_WIDTH; i++)
      if (sel_i[i]) wdat[i*8 +: 8] = dat_i[i*8 +: 8];
  end
  // storage: a write commits only on a handshake edge, never reset
  always_ff @(posedge clk) if (wr) mem[wa] <= wdat;
  // bus FSM: classic / burst handshakes, registered ack, err and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (cyc_i && stb_i && !ack_o && !err_o) begin
        if (!in_range) err_o <= 1'b1;
        else begin
          ack_o <= 1'b1;
          dat_o <= mem[word[MEM_ADDR_WIDTH-1:0]];
          if (cti_i == 3'b010) begin
            cnt <= word[MEM_ADDR_WIDTH-1:0];
            state <= BURST;
          end
        end
      end
    end else if (!cyc_i) begin
      ack_o <= 1'b0;
      state <= IDLE;
    end else if (!stb_i) ack_o <= 1'b0;
    else if (!ack_o) begin
      ack_o <= 1'b1;
      dat_o <= mem[cnt];
    end else if (cti_i == 3'b010) begin
      cnt <= nxt;
      dat_o <= (wr && nxt == cnt) ? wdat : mem[nxt];
    end else begin
      ack_o <= 1'b0;
      state <= IDLE;
    end
  end
endmodule
